// File: rtl/cdtimer_bank.sv
// cdtimer_bank: a bank of independent countdown timers behind a small register map.
// Each channel counts down on its selected timebase pulse and raises a sticky
// expiry flag when it reaches terminal count. In auto-reload mode it restarts
// from RELOAD; otherwise it parks at 0 until it is rewritten.
module cdtimer_bank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16
) (
  input  logic                                sysclk,
  input  logic                                sysreset_n,
  input  logic [1:0]                          counter_event,
  input  logic [$clog2(NUM_CH):0]             addr,
  input  logic [WIDTH-1:0]                    data_in,
  input  logic                                load,
  output logic [WIDTH-1:0]                    data_out,
  output logic [NUM_CH-1:0]                   expired,
  output logic                                any_expired
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int ADDR_W = CH_W + 1;

  // Per-channel state, gathered for readback and the expiry outputs
  logic [WIDTH-1:0] w_count  [NUM_CH];
  logic [2:0]       w_ctrl   [NUM_CH];
  logic [NUM_CH-1:0] w_sticky;
  logic [NUM_CH-1:0] w_enable;

  logic [CH_W-1:0]  w_ch;
  assign w_ch = addr[ADDR_W-1:1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] r_count;
      logic [WIDTH-1:0] r_reload;
      logic [2:0]       r_ctrl;     // {tb_sel, auto_reload, enable}
      logic             r_sticky;
      logic             w_sel;
      logic             w_wr_count;
      logic             w_wr_ctrl;
      logic             w_tick;

      assign w_sel      = (w_ch == CH_W'(gi));
      assign w_wr_count = load & w_sel & ~addr[0];
      assign w_wr_ctrl  = load & w_sel &  addr[0];
      assign w_tick     = counter_event[r_ctrl[2]] & r_ctrl[0];

      // Channel update: a COUNT write overrides any tick in the same cycle;
      // an expiry tick beats a simultaneous sticky clear so no event is lost.
      always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
          r_count  <= '0;
          r_reload <= '0;
          r_ctrl   <= '0;
          r_sticky <= 1'b0;
        end else if (w_wr_count) begin
          r_count  <= data_in;
          r_reload <= data_in;
          r_sticky <= 1'b0;
        end else begin
          if (w_wr_ctrl) begin
            r_ctrl <= data_in[2:0];
            if (data_in[3]) begin
              r_sticky <= 1'b0;
            end
          end
          if (w_tick) begin
            if (r_count > WIDTH'(1)) begin
              r_count <= r_count - WIDTH'(1);
            end else if (r_count == WIDTH'(1)) begin
              r_sticky <= 1'b1;
              r_count  <= r_ctrl[1] ? r_reload : '0;
            end
          end
        end
      end

      assign w_count[gi]  = r_count;
      assign w_ctrl[gi]   = r_ctrl;
      assign w_sticky[gi] = r_sticky;
      assign w_enable[gi] = r_ctrl[0];
    end
  endgenerate

  assign expired     = w_sticky;
  assign any_expired = |(w_sticky & w_enable);

  // Combinational readback of the addressed COUNT or CTRL register
  always_comb begin
    data_out = '0;
    if (addr[0]) begin
      data_out = {{(WIDTH-4){1'b0}}, w_sticky[w_ch], w_ctrl[w_ch]};
    end else begin
      data_out = w_count[w_ch];
    end
  end

endmodule

// File: tb/tb_cdtimer_bank.sv
// Directed bench for cdtimer_bank: a default 4x16 instance and an 8x32 instance.
module tb_cdtimer_bank;

  logic        clk;
  logic        rst_n;

  logic [1:0]  ev;
  logic [2:0]  addr;
  logic [15:0] din;
  logic        ld;
  logic [15:0] dout;
  logic [3:0]  expd;
  logic        anyx;

  logic [1:0]  ev8;
  logic [3:0]  addr8;
  logic [31:0] din8;
  logic        ld8;
  logic [31:0] dout8;
  logic [7:0]  expd8;
  logic        anyx8;

  int total;
  int bad;

  cdtimer_bank #(.NUM_CH(4), .WIDTH(16)) dut (
    .sysclk(clk), .sysreset_n(rst_n), .counter_event(ev), .addr(addr),
    .data_in(din), .load(ld), .data_out(dout), .expired(expd), .any_expired(anyx)
  );

  cdtimer_bank #(.NUM_CH(8), .WIDTH(32)) dut8 (
    .sysclk(clk), .sysreset_n(rst_n), .counter_event(ev8), .addr(addr8),
    .data_in(din8), .load(ld8), .data_out(dout8), .expired(expd8), .any_expired(anyx8)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Stimulus helpers: each returns 1 time unit after the active edge
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    addr = a; din = d; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  task automatic tick(input logic [1:0] e);
    ev = e;
    @(posedge clk); #1;
    ev = 2'b00;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] v);
    addr = a; #1;
    v = dout;
  endtask

  task automatic wr8(input logic [3:0] a, input logic [31:0] d);
    addr8 = a; din8 = d; ld8 = 1'b1;
    @(posedge clk); #1;
    ld8 = 1'b0;
  endtask

  task automatic tick8(input logic [1:0] e);
    ev8 = e;
    @(posedge clk); #1;
    ev8 = 2'b00;
  endtask

  task automatic rd8(input logic [3:0] a, output logic [31:0] v);
    addr8 = a; #1;
    v = dout8;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    logic [31:0] v8;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      total++;
      if (v !== 16'h0) begin bad++; $display("FAIL reset_readback addr=%0d got=%h want=0000", a, v); end
    end
    total++;
    if (expd !== 4'b0000) begin bad++; $display("FAIL reset_expired got=%b want=0000", expd); end
    total++;
    if (anyx !== 1'b0) begin bad++; $display("FAIL reset_any got=%b want=0", anyx); end
    for (int a = 0; a < 16; a++) begin
      rd8(4'(a), v8);
      total++;
      if (v8 !== 32'h0) begin bad++; $display("FAIL reset8_readback addr=%0d got=%h want=0", a, v8); end
    end
    total++;
    if (expd8 !== 8'h00) begin bad++; $display("FAIL reset8_expired got=%b want=0", expd8); end
    $display("test_reset: done");
  endtask

  task automatic test_oneshot;
    logic [15:0] v;
    logic [15:0] exp_cnt [3];
    exp_cnt[0] = 16'd2; exp_cnt[1] = 16'd1; exp_cnt[2] = 16'd0;
    wr(3'd4, 16'd3);
    wr(3'd5, 16'h1);
    for (int i = 0; i < 3; i++) begin
      tick(2'b01);
      rd(3'd4, v);
      total++;
      if (v !== exp_cnt[i]) begin bad++; $display("FAIL oneshot_count tick=%0d got=%0d want=%0d", i+1, v, exp_cnt[i]); end
      $display("oneshot tick %0d count=%0d expired=%b", i+1, v, expd);
      if (i < 2) begin
        total++;
        if (expd !== 4'b0000) begin bad++; $display("FAIL oneshot_early_exp tick=%0d got=%b want=0000", i+1, expd); end
      end
    end
    total++;
    if (expd !== 4'b0100) begin bad++; $display("FAIL oneshot_expired got=%b want=0100", expd); end
    total++;
    if (anyx !== 1'b1) begin bad++; $display("FAIL oneshot_any got=%b want=1", anyx); end
    tick(2'b01);
    tick(2'b01);
    rd(3'd4, v);
    total++;
    if (v !== 16'd0) begin bad++; $display("FAIL oneshot_idle got=%0d want=0", v); end
    rd(3'd5, v);
    total++;
    if (v !== 16'h9) begin bad++; $display("FAIL oneshot_ctrl got=%h want=0009", v); end
    wr(3'd5, 16'h8);
    total++;
    if (expd !== 4'b0000) begin bad++; $display("FAIL oneshot_w1c got=%b want=0000", expd); end
  endtask

  task automatic test_auto_reload;
    logic [15:0] v;
    logic [15:0] exp_cnt;
    logic        exp_flag;
    wr(3'd0, 16'd2);
    wr(3'd1, 16'h3);
    for (int i = 1; i <= 6; i++) begin
      tick(2'b01);
      exp_cnt  = (i % 2 == 1) ? 16'd1 : 16'd2;
      exp_flag = (i % 2 == 0);
      rd(3'd0, v);
      $display("auto tick %0d count=%0d expired=%b", i, v, expd);
      total++;
      if (v !== exp_cnt) begin bad++; $display("FAIL auto_count tick=%0d got=%0d want=%0d", i, v, exp_cnt); end
      total++;
      if (expd[0] !== exp_flag) begin bad++; $display("FAIL auto_exp tick=%0d got=%b want=%b", i, expd[0], exp_flag); end
      if (exp_flag) begin
        wr(3'd1, 16'hB);
        rd(3'd1, v);
        total++;
        if (v !== 16'h3) begin bad++; $display("FAIL auto_w1c tick=%0d ctrl got=%h want=0003", i, v); end
      end
    end
    wr(3'd1, 16'h8);
  endtask

  task automatic test_collision;
    logic [15:0] v;
    wr(3'd2, 16'd1);
    wr(3'd3, 16'h1);
    addr = 3'd2; din = 16'd5; ld = 1'b1; ev = 2'b01;
    @(posedge clk); #1;
    ld = 1'b0; ev = 2'b00;
    rd(3'd2, v);
    $display("collision write+tick count=%0d expired=%b", v, expd);
    total++;
    if (v !== 16'd5) begin bad++; $display("FAIL coll_write_count got=%0d want=5", v); end
    total++;
    if (expd[1] !== 1'b0) begin bad++; $display("FAIL coll_write_sticky got=%b want=0", expd[1]); end
    wr(3'd2, 16'd1);
    addr = 3'd3; din = 16'h9; ld = 1'b1; ev = 2'b01;
    @(posedge clk); #1;
    ld = 1'b0; ev = 2'b00;
    rd(3'd3, v);
    $display("collision w1c+expiry ctrl=%h expired=%b", v, expd);
    total++;
    if (expd[1] !== 1'b1) begin bad++; $display("FAIL coll_w1c_sticky got=%b want=1", expd[1]); end
    total++;
    if (v !== 16'h9) begin bad++; $display("FAIL coll_w1c_ctrl got=%h want=0009", v); end
    wr(3'd3, 16'h8);
  endtask

  task automatic test_tb_isolation;
    logic [15:0] v;
    wr(3'd2, 16'd2);
    wr(3'd3, 16'h5);
    wr(3'd6, 16'd2);
    wr(3'd7, 16'h1);
    tick(2'b01);
    tick(2'b01);
    rd(3'd2, v);
    $display("isolation us-only ch1=%0d expired=%b", v, expd);
    total++;
    if (expd !== 4'b1000) begin bad++; $display("FAIL iso_expired got=%b want=1000", expd); end
    total++;
    if (v !== 16'd2) begin bad++; $display("FAIL iso_ch1_count got=%0d want=2", v); end
    tick(2'b10);
    tick(2'b10);
    total++;
    if (expd !== 4'b1010) begin bad++; $display("FAIL iso_ms_expired got=%b want=1010", expd); end
    total++;
    if (anyx !== 1'b1) begin bad++; $display("FAIL iso_any_on got=%b want=1", anyx); end
    wr(3'd3, 16'h4);
    wr(3'd7, 16'h0);
    total++;
    if (expd !== 4'b1010) begin bad++; $display("FAIL iso_disable_keep got=%b want=1010", expd); end
    total++;
    if (anyx !== 1'b0) begin bad++; $display("FAIL iso_any_masked got=%b want=0", anyx); end
  endtask

  task automatic test_freeze;
    logic [15:0] v;
    wr(3'd0, 16'd3);
    wr(3'd1, 16'h1);
    tick(2'b01);
    wr(3'd1, 16'h0);
    tick(2'b01);
    rd(3'd0, v);
    total++;
    if (v !== 16'd2) begin bad++; $display("FAIL freeze_hold got=%0d want=2", v); end
    wr(3'd1, 16'h1);
    tick(2'b01);
    rd(3'd0, v);
    $display("freeze resume count=%0d", v);
    total++;
    if (v !== 16'd1) begin bad++; $display("FAIL freeze_resume got=%0d want=1", v); end
  endtask

  task automatic test_async_reset;
    logic [15:0] v;
    wr(3'd0, 16'h1234);
    wr(3'd1, 16'h3);
    tick(2'b01);
    #1 rst_n = 1'b0;
    #1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      total++;
      if (v !== 16'h0) begin bad++; $display("FAIL areset_readback addr=%0d got=%h want=0000", a, v); end
    end
    total++;
    if (expd !== 4'b0000) begin bad++; $display("FAIL areset_expired got=%b want=0000", expd); end
    total++;
    if (anyx !== 1'b0) begin bad++; $display("FAIL areset_any got=%b want=0", anyx); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick(2'b11);
    total++;
    if (expd !== 4'b0000) begin bad++; $display("FAIL areset_residual got=%b want=0000", expd); end
    rd(3'd0, v);
    total++;
    if (v !== 16'h0) begin bad++; $display("FAIL areset_count got=%h want=0000", v); end
    $display("async reset: expired=%b ch0=%h", expd, v);
  endtask

  task automatic test_sweep;
    logic [31:0] v;
    logic [31:0] exp_cnt [3];
    wr8(4'b1110, 32'hFFFF_FFFF);
    wr8(4'b1111, 32'h1);
    tick8(2'b01);
    rd8(4'b1110, v);
    $display("sweep ch7 count=%h", v);
    total++;
    if (v !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sweep_dec got=%h want=fffffffe", v); end
    total++;
    if (expd8 !== 8'h00) begin bad++; $display("FAIL sweep_noexp got=%b want=0", expd8); end
    exp_cnt[0] = 32'd2; exp_cnt[1] = 32'd1; exp_cnt[2] = 32'd0;
    wr8(4'b1110, 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick8(2'b01);
      rd8(4'b1110, v);
      total++;
      if (v !== exp_cnt[i]) begin bad++; $display("FAIL sweep_count tick=%0d got=%0d want=%0d", i+1, v, exp_cnt[i]); end
    end
    total++;
    if (expd8 !== 8'h80) begin bad++; $display("FAIL sweep_expired got=%b want=10000000", expd8); end
    total++;
    if (anyx8 !== 1'b1) begin bad++; $display("FAIL sweep_any got=%b want=1", anyx8); end
    rd8(4'b1111, v);
    total++;
    if (v !== 32'h9) begin bad++; $display("FAIL sweep_ctrl got=%h want=9", v); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    ev = 2'b00; addr = '0; din = '0; ld = 1'b0;
    ev8 = 2'b00; addr8 = '0; din8 = '0; ld8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_oneshot;
    test_auto_reload;
    test_collision;
    test_tb_isolation;
    test_freeze;
    test_async_reset;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
